// File: rtl/paddle_if.sv
// Purpose : button-strobe / paddle-position bundle between the conditioning logic and paddle_ctrl.
// Latency : n/a (signal bundle only).
// Backpres: none; strobes are single-cycle pulses and outputs are level signals.
// Ports   : en, center, btn_up, btn_down (to controller); paddle_y, moving_up, moving_down (from controller).
interface paddle_if #(
  parameter int Y_W = 11
);
  logic           en;
  logic           center;
  logic           btn_up;
  logic           btn_down;
  logic [Y_W-1:0] paddle_y;
  logic           moving_up;
  logic           moving_down;

  // Producer of strobes / consumer of position.
  modport master (
    output en, center, btn_up, btn_down,
    input  paddle_y, moving_up, moving_down
  );

  // The paddle controller itself.
  modport slave (
    input  en, center, btn_up, btn_down,
    output paddle_y, moving_up, moving_down
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Purpose : turns debounced up/down strobes into a clamped, hold-to-accelerate paddle position.
// Latency : 1 cycle; a strobe accepted at cycle N shows on paddle_y at cycle N+1.
// Backpres: none; every strobe is consumed or dropped (en==0 / conflict) in the cycle it arrives.
// Ports   : clk, rst (sync, active-low); pif (slave): en, center, btn_up, btn_down in;
//           paddle_y, moving_up, moving_down out (all registered / decoded from registered state).
module paddle_ctrl #(
  parameter int Y_W        = 11,
  parameter int SCREEN_H   = 768,
  parameter int PADDLE_H   = 96,
  parameter int STEP_MIN   = 4,
  parameter int STEP_MAX   = 16,
  parameter int ACCEL_HOLD = 4,
  parameter int GAP_CYCLES = 1_000_000
) (
  input logic     clk,
  input logic     rst,
  paddle_if.slave pif
);

  localparam int Y_MAX = SCREEN_H - PADDLE_H;
  localparam int RUN_W = $clog2(ACCEL_HOLD + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [Y_W-1:0]   Y_CENTER   = Y_W'(Y_MAX / 2);
  localparam logic [Y_W-1:0]   Y_MAX_Y    = Y_W'(Y_MAX);
  localparam logic [Y_W:0]     Y_MAX_X    = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0]   STEP_MIN_Y = Y_W'(STEP_MIN);
  localparam logic [Y_W-1:0]   STEP_MAX_Y = Y_W'(STEP_MAX);
  localparam logic [Y_W:0]     STEP_MAX_X = (Y_W+1)'(STEP_MAX);
  localparam logic [RUN_W-1:0] RUN_HOLD   = RUN_W'(ACCEL_HOLD);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state_q, state_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [Y_W-1:0]   step_q, step_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // Scratch values for the move computation.
  state_t           dir_st;
  logic [Y_W-1:0]   mv;
  logic [Y_W:0]     sum;
  logic [Y_W:0]     step_x2;
  logic [RUN_W-1:0] run_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= Y_CENTER;
      step_q  <= STEP_MIN_Y;
      run_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      step_q  <= step_d;
      run_q   <= run_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    step_d  = step_q;
    run_d   = run_q;
    // Idle-gap counter runs every cycle (even with en low) and parks at its last value.
    gap_d   = (gap_q == GAP_LAST) ? gap_q : gap_q + 1'b1;
    dir_st  = IDLE;
    mv      = STEP_MIN_Y;
    sum     = '0;
    step_x2 = {step_q, 1'b0};
    run_inc = run_q + 1'b1;

    if (pif.center) begin
      // New serve: wins over en and any strobe in the same cycle.
      state_d = IDLE;
      y_d     = Y_CENTER;
      step_d  = STEP_MIN_Y;
      run_d   = '0;
      gap_d   = '0;
    end else if (!pif.en) begin
      // Frozen: only the gap counter advances.
    end else if (pif.btn_up && pif.btn_down) begin
      // Conflicting strobes: hold position, drop all acceleration.
      state_d = IDLE;
      step_d  = STEP_MIN_Y;
      run_d   = '0;
      gap_d   = '0;
    end else if (pif.btn_up || pif.btn_down) begin
      dir_st = pif.btn_up ? UP : DOWN;
      gap_d  = '0;
      if (state_q == dir_st) begin
        // Same direction: move by the current step; a doubled step applies from the next strobe.
        mv = step_q;
        if (run_inc == RUN_HOLD) begin
          run_d  = '0;
          step_d = (step_x2 > STEP_MAX_X) ? STEP_MAX_Y : step_x2[Y_W-1:0];
        end else begin
          run_d = run_inc;
        end
      end else begin
        // From IDLE or a reversal: restart at the minimum step.
        state_d = dir_st;
        step_d  = STEP_MIN_Y;
        run_d   = RUN_W'(1);
      end

      if (dir_st == UP) begin
        y_d = (y_q < mv) ? '0 : y_q - mv;
      end else begin
        // One extra bit so the bottom clamp cannot be fooled by wrap-around.
        sum = {1'b0, y_q} + {1'b0, mv};
        y_d = (sum > Y_MAX_X) ? Y_MAX_Y : sum[Y_W-1:0];
      end
    end else if ((state_q != IDLE) && (gap_q == GAP_LAST)) begin
      // Player let go long enough: cancel acceleration.
      state_d = IDLE;
      step_d  = STEP_MIN_Y;
      run_d   = '0;
    end
  end

  assign pif.paddle_y    = y_q;
  assign pif.moving_up   = (state_q == UP);
  assign pif.moving_down = (state_q == DOWN);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Purpose : self-checking bench for paddle_ctrl; integer reference model plus literal spot checks.
// Latency : model is updated on each posedge, DUT compared on each negedge.
// Backpres: n/a.
module tb_paddle_ctrl;
  localparam int Y_W   = 11;
  localparam int GAP   = 40;  // shortened idle timeout so the bench stays short
  localparam int YMAX  = 672;
  localparam int YCEN  = 336;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  paddle_if #(.Y_W(Y_W)) pif ();

  paddle_ctrl #(
    .Y_W(Y_W), .SCREEN_H(768), .PADDLE_H(96), .STEP_MIN(4),
    .STEP_MAX(16), .ACCEL_HOLD(4), .GAP_CYCLES(GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  // ---------------- reference model (plain integers) ----------------
  int m_y    = YCEN;
  int m_dir  = 0;   // -1 up, 0 idle, +1 down
  int m_step = 4;
  int m_run  = 0;
  int m_idle = 0;   // cycles since last accepted strobe, capped at GAP-1

  always @(posedge clk) begin
    int d;
    int mv;
    if (!rst) begin
      m_y = YCEN; m_dir = 0; m_step = 4; m_run = 0; m_idle = 0;
    end else if (pif.center) begin
      m_y = YCEN; m_dir = 0; m_step = 4; m_run = 0; m_idle = 0;
    end else if (!pif.en) begin
      m_idle = (m_idle + 1 > GAP - 1) ? GAP - 1 : m_idle + 1;
    end else if (pif.btn_up && pif.btn_down) begin
      m_dir = 0; m_step = 4; m_run = 0; m_idle = 0;
    end else if (pif.btn_up || pif.btn_down) begin
      d = pif.btn_up ? -1 : 1;
      if (m_dir == d) begin
        mv = m_step;
        m_run = m_run + 1;
        if (m_run == 4) begin
          m_step = (m_step * 2 > 16) ? 16 : m_step * 2;
          m_run  = 0;
        end
      end else begin
        mv = 4; m_dir = d; m_step = 4; m_run = 1;
      end
      m_y = m_y + d * mv;
      if (m_y < 0)    m_y = 0;
      if (m_y > YMAX) m_y = YMAX;
      m_idle = 0;
    end else begin
      if (m_dir != 0 && m_idle == GAP - 1) begin
        m_dir = 0; m_step = 4; m_run = 0;
      end
      m_idle = (m_idle + 1 > GAP - 1) ? GAP - 1 : m_idle + 1;
    end
  end

  // ---------------- compare process ----------------
  int    checks   = 0;
  int    failures = 0;
  bit    cmp_on   = 1'b0;
  int    lit_req  = 0;
  int    lit_done = 0;
  string lit_name = "";
  int    lit_y    = 0;
  logic  lit_up   = 1'b0;
  logic  lit_dn   = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (pif.paddle_y !== Y_W'(m_y) || pif.moving_up !== (m_dir < 0) ||
          pif.moving_down !== (m_dir > 0)) begin
        failures++;
        $display("FAIL model t=%0t got y=%0d up=%b dn=%b want y=%0d up=%b dn=%b",
                 $time, pif.paddle_y, pif.moving_up, pif.moving_down,
                 m_y, (m_dir < 0), (m_dir > 0));
      end
      if (lit_req != lit_done) begin
        lit_done = lit_req;
        checks++;
        if (pif.paddle_y !== Y_W'(lit_y) || pif.moving_up !== lit_up ||
            pif.moving_down !== lit_dn) begin
          failures++;
          $display("FAIL %s got y=%0d up=%b dn=%b want y=%0d up=%b dn=%b",
                   lit_name, pif.paddle_y, pif.moving_up, pif.moving_down,
                   lit_y, lit_up, lit_dn);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle strobe followed by `gap_after` quiet cycles.
  task automatic strobe(input bit up, input bit dn, input int gap_after);
    pif.btn_up = up; pif.btn_down = dn;
    tick();
    pif.btn_up = 1'b0; pif.btn_down = 1'b0;
    idle(gap_after);
  endtask

  // Hand-computed expectation, checked by the compare process at the coming negedge.
  task automatic expect_lit(input string name, input int y, input logic up, input logic dn);
    lit_name = name; lit_y = y; lit_up = up; lit_dn = dn;
    lit_req++;
  endtask

  initial begin
    pif.en = 1'b1; pif.center = 1'b0; pif.btn_up = 1'b0; pif.btn_down = 1'b0;
    rst = 1'b0;
    tick();
    cmp_on = 1'b1;
    idle(2);
    rst = 1'b1;
    tick();
    expect_lit("reset", 336, 1'b0, 1'b0);

    // Acceleration: first 4 strobes step 4, next 4 step 8, then 16 saturating.
    strobe(0, 1, 0); expect_lit("down1", 340, 1'b0, 1'b1); idle(9);
    strobe(0, 1, 9);
    strobe(0, 1, 9);
    strobe(0, 1, 0); expect_lit("down4", 352, 1'b0, 1'b1); idle(9);
    strobe(0, 1, 0); expect_lit("down5_step8", 360, 1'b0, 1'b1); idle(9);
    for (int i = 0; i < 3; i++) strobe(0, 1, 9);
    strobe(0, 1, 0); expect_lit("down9_step16", 400, 1'b0, 1'b1); idle(9);
    for (int i = 0; i < 3; i++) strobe(0, 1, 9);
    strobe(0, 1, 0); expect_lit("down13_sat16", 464, 1'b0, 1'b1); idle(3);

    // Reset mid-move discards acceleration.
    rst = 1'b0; tick(); rst = 1'b1;
    expect_lit("reset_mid_move", 336, 1'b0, 1'b0);
    idle(1);
    strobe(0, 1, 0); expect_lit("post_reset_step4", 340, 1'b0, 1'b1); idle(2);

    // Run into the bottom edge.
    for (int i = 0; i < 30; i++) strobe(0, 1, 1);
    expect_lit("bottom_clamp", 672, 1'b0, 1'b1);

    // 672 -> up x4 -> 656, conflict, up -> 652, down x4 -> 668 (step 8), down -> clamp 672.
    for (int i = 0; i < 4; i++) strobe(1, 0, 1);
    expect_lit("reverse_up4", 656, 1'b1, 1'b0);
    strobe(1, 1, 0); expect_lit("conflict_hold", 656, 1'b0, 1'b0); idle(1);
    strobe(1, 0, 0); expect_lit("after_conflict_step4", 652, 1'b1, 1'b0); idle(1);
    for (int i = 0; i < 4; i++) strobe(0, 1, 1);
    expect_lit("down_to_668", 668, 1'b0, 1'b1);
    strobe(0, 1, 0); expect_lit("clamp_668_step8", 672, 1'b0, 1'b1); idle(1);

    // Run into the top edge.
    for (int i = 0; i < 60; i++) strobe(1, 0, 1);
    expect_lit("top_clamp", 0, 1'b1, 1'b0);

    // Idle-gap timeout.
    pif.center = 1'b1; tick(); pif.center = 1'b0;
    expect_lit("center", 336, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(0, 1, 1);
    expect_lit("gap_setup", 352, 1'b0, 1'b1);
    idle(GAP - 3);                      // next strobe lands at idle count GAP-2
    strobe(0, 1, 0); expect_lit("strobe_before_gap_step8", 360, 1'b0, 1'b1);
    idle(GAP - 1);
    expect_lit("gap_minus1_still_down", 360, 1'b0, 1'b1);
    idle(1);
    expect_lit("gap_timeout_idle", 360, 1'b0, 1'b0);
    idle(5);
    strobe(0, 1, 0); expect_lit("after_gap_step4", 364, 1'b0, 1'b1); idle(1);

    // Enable gate, then centre overriding en==0 and a simultaneous strobe.
    pif.en = 1'b0;
    for (int i = 0; i < 3; i++) strobe(1, 0, 1);
    expect_lit("en0_frozen", 364, 1'b0, 1'b1);
    pif.center = 1'b1; pif.btn_down = 1'b1;
    tick();
    pif.center = 1'b0; pif.btn_down = 1'b0;
    expect_lit("center_en0", 336, 1'b0, 1'b0);
    idle(2);
    pif.en = 1'b1;
    strobe(1, 0, 0); expect_lit("resume_up", 332, 1'b1, 1'b0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
